// File: rtl/match_event_logger_if.sv
// Event read-out bus between the match logger (master) and the host (slave).
// The master presents a show-ahead head timestamp and the host acknowledges it
// with evt_ready while evt_valid is high.
interface match_event_logger_if #(
  parameter int TS_W = 16
);
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/match_event_logger.sv
// Match event logger: turns each rising edge of a sequence detector output
// into a timestamped event, buffers the timestamps in a small show-ahead FIFO
// drained over valid/ready, and keeps a saturating event count plus a sticky
// flag recording that at least one event was lost to a full FIFO.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 match_in,
  input  logic                 clear,
  match_event_logger_if.master evt,
  output logic [CNT_W-1:0]     match_count,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0] ts;
  logic            match_d;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];

  logic            evt_hit;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  // Decode edge detection, FIFO status and push/pop/drop for this cycle.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    evt_hit = 1'b0;
    empty   = 1'b0;
    full    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;

    evt_hit = match_in & ~match_d;
    empty   = (wr_ptr == rd_ptr);
    // Same slot index but different wrap bit means the writer lapped the reader.
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop     = ~empty & evt.evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
    push    = evt_hit & (~full | pop);
    drop    = evt_hit & full & ~pop;
  end

  // Free-running timestamp, edge-detect register and FIFO pointers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts      <= '0;
      match_d <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      ts      <= ts + 1'b1;
      match_d <= match_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage write: the tail receives the timestamp of the sampling edge.
  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr[AW-1:0]] <= ts;
  end

  // Saturating event counter and sticky overflow; clear acts first, then the event.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      match_count <= evt_hit ? CNT_W'(1) : '0;
      overflow    <= drop;
    end else begin
      if (evt_hit && match_count != CNT_MAX) match_count <= match_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Show-ahead head entry; forced to zero while empty so the bus is defined.
  assign evt.evt_valid = ~empty;
  assign evt.evt_ts    = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer for the serial sequence detectors (Moore110 family). It watches the detector's single-bit `out`, turns each rising edge into one match event, and stamps it with a free-running cycle count. It buffers up to DEPTH timestamps in a FIFO that a host drains over a valid/ready handshake. It also keeps a saturating total match count and a sticky overflow flag.

## Interface
- TS_W, 16, timestamp width; the cycle counter wraps modulo 2^TS_W
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 8, match counter width
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
- match_in  input  1  detector `out`, sampled on clk
- clear  input  1  synchronous clear of match_count and overflow only
- evt_ready  input  1  host accepts head entry
- evt_valid  output  1  FIFO non-empty
- evt_ts  output  TS_W  head-entry timestamp; valid only while evt_valid
- match_count  output  CNT_W  total detected events, saturating
- overflow  output  1  sticky: at least one event was dropped

## Operation
- Timestamp counter `ts`: resets to 0 and increments by 1 every cycle with no stall. It wraps from 2^TS_W−1 to 0.
- Edge detect: register `match_d` resets to 0.
- `event = match_in & ~match_d` evaluated at each edge.
- A level held high for N cycles produces exactly one event.
- A high level on the first edge after reset produces an event.
- Push: on an event, the current `ts` value (before its increment at that edge) is written to the tail.
- Show-ahead FIFO. `evt_valid = ~empty`, and `evt_ts` is driven from the head entry.
- Pop when `evt_valid & evt_ready`.
- Full FIFO:
  - Event with no pop in the same cycle: the event is dropped, the FIFO is unchanged, and `overflow` is set to 1.
  - Event with a pop in the same cycle: both the push and the pop occur, there is no drop, and the FIFO stays full.
- Empty FIFO with event and evt_ready=1: push only. Nothing is popped because evt_valid was 0 that cycle.
- Read and write pointers are log2(DEPTH)+1 bits. Full and empty are decoded from the MSB and the remaining bits.
- match_count:
  - Increments on every event, whether stored or dropped.
  - Saturates at 2^CNT_W−1.
- clear:
  - Forces match_count and overflow to 0.
  - A coincident event is still processed after the clear: count becomes 1, and overflow becomes 1 only if that event is dropped.
  - The FIFO and `ts` are unaffected.
- Reset priority is over everything. Reset mid-operation discards all FIFO contents.

## Timing
- Reset values: evt_valid=0, evt_ts=0, match_count=0, overflow=0, ts=0, match_d=0, pointers=0.
- Latency: an event sampled at edge k gives evt_valid=1 and the correct evt_ts during cycle k+1. match_count updates at that same edge.
- Overflow asserts in the cycle after the dropping edge.
- Pop at edge k: the next head, or evt_valid=0, appears in cycle k+1.
- Throughput: one push and one pop per cycle. Events can be no closer than every 2 cycles because of edge detection.
- evt_ts is held stable while evt_valid=1 and evt_ready=0.

## Test plan
All scenarios use TS_W=16, DEPTH=4, CNT_W=8. The first edge after reset release carries ts=0.
- Reset hold for 3 cycles with match_in=1 -> all outputs 0 during reset. The event at the first post-reset edge gives evt_ts=0 and match_count=1.
- Single 1-cycle pulse sampled at ts=5, evt_ready=0 -> evt_valid=1 and evt_ts=5 from the next cycle, held for 10 cycles. Then evt_ready=1 for 1 cycle -> evt_valid=0.
- match_in high for 3 cycles from ts=7 -> exactly one entry with evt_ts=7, match_count=1.
- Pulses at ts=2,4,6,8,10 with evt_ready=0 ->
  - match_count=5 and overflow=1.
  - Draining returns 2,4,6,8, then evt_valid=0.
  - Repeat the sequence with evt_ready=1 at ts=10 -> overflow stays 0.
- 260 events, draining as needed ->
  - match_count saturates at 255.
  - clear together with an event -> match_count=1, overflow=0.
- 2 entries queued, then reset pulsed mid-stream -> evt_valid=0 and match_count=0 in the cycle after reset. The next event is stamped relative to ts restarting at 0.
